// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encoding and line-mux select constants for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    // Idle and stop share the marking level, so both select the stop input.
    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_START:  sel = SEL_START;
            ST_DATA:   sel = SEL_DATA;
            ST_PARITY: sel = SEL_PAR;
            default:   sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - even/odd parity of a data word
module parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  logic             par_typ,
    output logic             par_bit
);

    assign par_bit = (^word) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driving the line-mux select, data bit and parity bit
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] P_DATA,
    input  logic                 DATA_VALID,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [1:0]           mux_sel,
    output logic                 SER_DATA,
    output logic                 PAR_BIT,
    output logic                 busy_in
);

    localparam int CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUS_WIDTH - 1);

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [BUS_WIDTH-1:0]   word_q,    word_d;
    logic                   par_en_q,  par_en_d;
    logic                   par_typ_q, par_typ_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        case (state_q)
            ST_IDLE, ST_STOP: begin
                // STOP doubles as an accept point so frames can run back to back.
                if (DATA_VALID) begin
                    state_d   = ST_START;
                    word_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    parity_calc #(
        .WIDTH(BUS_WIDTH)
    ) u_parity (
        .word    (word_q),
        .par_typ (par_typ_q),
        .par_bit (PAR_BIT)
    );

    assign mux_sel  = sel_of(state_q);
    assign busy_in  = (state_q != ST_IDLE);
    assign SER_DATA = (state_q == ST_DATA) & word_q[cnt_q];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl against a frame-position model
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [1:0]   mux_sel;
    logic         SER_DATA;
    logic         PAR_BIT;
    logic         busy_in;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.BUS_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .SER_DATA   (SER_DATA),
        .PAR_BIT    (PAR_BIT),
        .busy_in    (busy_in)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current frame (-1 = idle), plus the word captured at acceptance.
    int         pos  = -1;
    int         flen = 0;
    logic [W-1:0] m_word = '0;
    logic       m_pen = 1'b0;
    logic       m_pt  = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos = -1; m_word = '0; m_pen = 1'b0; m_pt = 1'b0;
        end else if (pos < 0 || pos == flen - 1) begin
            if (DATA_VALID) begin
                m_word = P_DATA; m_pen = PAR_EN; m_pt = PAR_TYP;
                pos = 0;
                flen = W + 2 + int'(PAR_EN);
            end else begin
                pos = -1;
            end
        end else begin
            pos++;
        end
    end

    always @(posedge CLK) begin
        logic [1:0] exp_sel;
        #2;
        if (pos < 0)                    exp_sel = 2'b01;
        else if (pos == 0)              exp_sel = 2'b00;
        else if (pos <= W)              exp_sel = 2'b10;
        else if (m_pen && pos == W + 1) exp_sel = 2'b11;
        else                            exp_sel = 2'b01;
        chk("model_sel", mux_sel, exp_sel);
        chk("model_busy", busy_in, pos >= 0);
        if (pos >= 1 && pos <= W) chk("model_ser", SER_DATA, m_word[pos-1]);
        if (pos >= 0)             chk("model_par", PAR_BIT, (^m_word) ^ m_pt);
        if (RST) begin
            chk("model_rst_ser", SER_DATA, 1'b0);
            chk("model_rst_par", PAR_BIT, 1'b0);
        end
    end

    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input int inject_at,
                             output logic [7:0] bits, output int busy_n, output logic parb,
                             output logic saw_par, output int lat);
        int  k = 0;
        bit  started = 0;
        bit  done = 0;
        bits = '0; busy_n = 0; parb = 1'b0; saw_par = 1'b0; lat = -1;
        DATA_VALID = 1'b1; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        for (int c = 0; c < 30 && !done; c++) begin
            @(posedge CLK); #3;
            if (busy_in) begin
                if (!started) lat = c;
                started = 1;
                busy_n++;
                if (mux_sel == 2'b10 && k < 8) begin bits[k] = SER_DATA; k++; end
                if (mux_sel == 2'b11) begin saw_par = 1'b1; parb = PAR_BIT; end
            end else if (started) begin
                done = 1;
            end
            if (c == 0) begin DATA_VALID = 1'b0; P_DATA = ~d; PAR_TYP = ~pt; end
            if (c == inject_at) begin DATA_VALID = 1'b1; P_DATA = 8'hFF; end
            if (c == inject_at + 1) DATA_VALID = 1'b0;
        end
        chk("frame_end", done, 1'b1);
    endtask

    initial begin
        logic [7:0]  bits;
        logic [15:0] bits16;
        int          busy_n, lat, k;
        logic        parb, saw_par, gap, stray;
        logic [1:0]  sel9, sel10;

        #1;
        chk("rst_sel", mux_sel, 2'b01);
        chk("rst_busy", busy_in, 1'b0);
        chk("rst_ser", SER_DATA, 1'b0);
        chk("rst_par", PAR_BIT, 1'b0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        @(posedge CLK); #3;

        run_frame(8'hA5, 1'b0, 1'b0, -1, bits, busy_n, parb, saw_par, lat);
        chk("a5_bits", bits, 8'hA5);
        chk("a5_busy", busy_n, 10);
        chk("a5_nopar", saw_par, 1'b0);
        chk("a5_latency", lat, 0);

        run_frame(8'h07, 1'b1, 1'b0, -1, bits, busy_n, parb, saw_par, lat);
        chk("07e_bits", bits, 8'h07);
        chk("07e_len", busy_n, 11);
        chk("07e_saw", saw_par, 1'b1);
        chk("07e_par", parb, 1'b1);

        run_frame(8'h07, 1'b1, 1'b1, -1, bits, busy_n, parb, saw_par, lat);
        chk("07o_len", busy_n, 11);
        chk("07o_par", parb, 1'b0);

        // Back-to-back: DATA_VALID held across frame 1's STOP.
        DATA_VALID = 1'b1; P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        bits16 = '0; k = 0; busy_n = 0; gap = 1'b0; sel9 = 2'b00; sel10 = 2'b01;
        for (int c = 0; c < 24; c++) begin
            @(posedge CLK); #3;
            if (c < 20 && !busy_in) gap = 1'b1;
            if (busy_in) busy_n++;
            if (mux_sel == 2'b10 && k < 16) begin bits16[k] = SER_DATA; k++; end
            if (c == 9)  sel9  = mux_sel;
            if (c == 10) sel10 = mux_sel;
            if (c == 0)  P_DATA = 8'h80;
            if (c == 11) DATA_VALID = 1'b0;
        end
        chk("b2b_bits", bits16, 16'h8001);
        chk("b2b_busy", busy_n, 20);
        chk("b2b_gap", gap, 1'b0);
        chk("b2b_stop", sel9, 2'b01);
        chk("b2b_start", sel10, 2'b00);

        run_frame(8'h00, 1'b0, 1'b0, 3, bits, busy_n, parb, saw_par, lat);
        chk("ign_bits", bits, 8'h00);
        chk("ign_len", busy_n, 10);
        stray = 1'b0;
        repeat (12) begin @(posedge CLK); #3; if (busy_in) stray = 1'b1; end
        chk("ign_noframe", stray, 1'b0);

        // Abort in DATA cycle 4 (START is c=0, DATA bit k is c=k+1).
        DATA_VALID = 1'b1; P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #3;
            if (c == 0) DATA_VALID = 1'b0;
        end
        chk("pre_abort_sel", mux_sel, 2'b10);
        RST = 1'b1;
        #1;
        chk("abort_sel", mux_sel, 2'b01);
        chk("abort_busy", busy_in, 1'b0);
        chk("abort_ser", SER_DATA, 1'b0);
        chk("abort_par", PAR_BIT, 1'b0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        stray = 1'b0;
        repeat (20) begin @(posedge CLK); #3; if (busy_in || mux_sel != 2'b01) stray = 1'b1; end
        chk("post_abort_idle", stray, 1'b0);

        run_frame(8'h3C, 1'b1, 1'b1, -1, bits, busy_n, parb, saw_par, lat);
        chk("3c_bits", bits, 8'h3C);
        chk("3c_len", busy_n, 11);
        chk("3c_par", parb, 1'b1);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
